// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared types and constants for the restoring divider
// DIV_SIGNED_EN adds the FIXUP state used by the two's-complement build.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_e;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
`endif

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - operand/result handshake bundle for the divider
interface seq_restoring_divider_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// rtl/seq_restoring_divider_step.sv - one combinational restoring-division step
module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;

  // Ripple-carry subtract over WIDTH+1 bits; final carry-out means no borrow.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_sub_b = ~{1'b0, i_divisor};
    w_diff  = '0;
    w_carry = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i < WIDTH) begin
        w_diff[i] = w_shift[i] ^ w_sub_b[i] ^ w_carry;
      end
      w_carry = (w_shift[i] & w_sub_b[i]) | (w_carry & (w_shift[i] ^ w_sub_b[i]));
    end
    o_qbit = w_carry;
    o_rem  = w_carry ? w_diff : w_shift[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative restoring divider, one quotient bit per clock
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_zero_dvs;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dvs_mag = bus.divisor;
`endif

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_zero_dvs = (bus.divisor == '0);
  assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = w_zero_dvs ? DONE : CALC;
`ifdef DIV_SIGNED_EN
      CALC:  if (r_cnt == '0) w_next_state = FIXUP;
      FIXUP: w_next_state = DONE;
`else
      CALC: if (r_cnt == '0) w_next_state = DONE;
`endif
      DONE: if (r_out_valid && bus.out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd <= w_dvd_mag;
            r_dvs <= w_dvs_mag;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
            r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r <= bus.dividend[WIDTH-1];
`endif
            // Zero divisor skips CALC; out_valid follows one edge later from DONE.
            if (w_zero_dvs) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
`ifndef DIV_SIGNED_EN
          if (r_cnt == '0) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        FIXUP: begin
          r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
          r_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (!r_out_valid)         r_out_valid <= 1'b1;
          else if (bus.out_ready)   r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    int sa;
    int sb;
    sa = 0;
    sb = 0;
    if (b == '0) begin
      q   = '1;
      r   = a;
      dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      sa = int'(a);
      sb = int'(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`endif
      dbz = 1'b0;
    end
  endtask

  // Waits for the result after the accepting edge, checks it, optionally stalls, then transfers.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input bit release_it);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    int           cyc;
    model(a, b, eq, er, edbz);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("latency", cyc, edbz ? 1 : LAT);
    check_eq("quotient", bus.quotient, eq);
    check_eq("remainder", bus.remainder, er);
    check_eq("div_by_zero", bus.div_by_zero, edbz);
`ifndef DIV_SIGNED_EN
    if (!edbz) begin
      check_eq("invariant", bus.quotient * b + bus.remainder, a);
      check_eq("rem_lt_div", bus.remainder < b, 1);
    end
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("stall_valid", bus.out_valid, 1);
      check_eq("stall_q", bus.quotient, eq);
      check_eq("stall_r", bus.remainder, er);
    end
    if (release_it) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_eq("valid_drop", bus.out_valid, 0);
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    check_eq("in_ready_busy", bus.in_ready, 0);
    collect(a, b, stall, 1'b1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_quotient", bus.quotient, 0);
    check_eq("rst_remainder", bus.remainder, 0);
    check_eq("rst_dbz", bus.div_by_zero, 0);

    run_div(8'd200, 8'd7, 0);
    run_div(8'd255, 8'd1, 0);
    run_div(8'd5, 8'd9, 0);
    run_div(8'd0, 8'd3, 0);
    run_div(8'd100, 8'd0, 0);
    run_div(8'hF9, 8'h02, 0);
    run_div(8'h80, 8'hFF, 0);

    // Backpressure: result must hold and a pending 9/3 must wait for the transfer.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    tick();
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    collect(8'd200, 8'd7, 5, 1'b0);
    check_eq("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("bp_valid_drop", bus.out_valid, 0);
    check_eq("bp_in_ready_after", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("bp_accepted", bus.in_ready, 0);
    collect(8'd9, 8'd3, 0, 1'b1);

    // Reset in the middle of CALC drops the in-flight result.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd6;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", bus.out_valid, 0);
    check_eq("midrst_q", bus.quotient, 0);
    check_eq("midrst_r", bus.remainder, 0);
    tick();
    #3 rst_n = 1'b1;
    repeat (12) tick();
    check_eq("midrst_no_stale", bus.out_valid, 0);
    check_eq("midrst_idle", bus.in_ready, 1);
    run_div(8'd50, 8'd6, 0);

    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_div(a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
